// File: rtl/hover_controller.sv
// ----------------------------------------------------------------------------
// hover_controller
//   Turns the five front-panel push buttons into the on-screen cursor of the
//   sale terminal. Keys and the mode switch are synchronized and debounced;
//   presses are latched as pending flags and serviced one per frame, so the
//   highlight only moves at frame boundaries.
//
// Ports
//   CLK, RST_N                  clock, asynchronous active-low reset
//   KEY_LEFT/RIGHT/UP/DOWN/SEL  raw active-low keys (asynchronous)
//   SW2                         raw mode switch: 0 product grid, 1 basket list
//   FrameStart                  one-cycle pulse at start of vertical blanking
//   BasketCount[3:0]            valid basket rows, 0..12
//   HighlightedProductList[11:0] one-hot (or zero) highlight vector
//   CursorIndex[3:0]            grid index (mode 0) or basket row (mode 1)
//   SelectPulse, RemovePulse    one-cycle add / remove requests
//   SelectedID[3:0]             index qualified by either pulse
// ----------------------------------------------------------------------------
module hover_controller #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DB_CNTR_WIDTH   = 18
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        KEY_LEFT,
   input  logic        KEY_RIGHT,
   input  logic        KEY_UP,
   input  logic        KEY_DOWN,
   input  logic        KEY_SEL,
   input  logic        SW2,
   input  logic        FrameStart,
   input  logic [3:0]  BasketCount,
   output logic [11:0] HighlightedProductList,
   output logic [3:0]  CursorIndex,
   output logic        SelectPulse,
   output logic        RemovePulse,
   output logic [3:0]  SelectedID
);

   // Input channel indices; bit 5 is the mode switch.
   localparam int K_LEFT  = 0;
   localparam int K_RIGHT = 1;
   localparam int K_UP    = 2;
   localparam int K_DOWN  = 3;
   localparam int K_SEL   = 4;
   localparam int K_MODE  = 5;
   localparam int NCH     = 6;

   // Keys idle high (released), the switch idles low (grid mode).
   localparam logic [NCH-1:0] IN_RST = 6'b01_1111;
   localparam logic [DB_CNTR_WIDTH-1:0] DB_LAST = DB_CNTR_WIDTH'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, APPLY, PULSE} state_t;

   logic [NCH-1:0]                    raw;
   logic [NCH-1:0]                    sync1_q, sync2_q;
   logic [NCH-1:0]                    db_q, db_d, db_prev_q;
   logic [NCH-1:0][DB_CNTR_WIDTH-1:0] cnt_q, cnt_d;
   logic [4:0]                        press_evt;
   logic                              mode, mode_chg;
   logic [4:0]                        pend_q, pend_d;
   logic [4:0]                        svc;
   state_t                            state_q, state_d;
   logic [3:0]                        grid_q, grid_d;
   logic [3:0]                        bsk_q, bsk_d;
   logic [1:0]                        row, col, row_n, col_n;
   logic [3:0]                        bsk_last;
   logic [11:0]                       hpl_q, hpl_d;
   logic [3:0]                        cur_q, cur_d;
   logic                              selp_q, selp_d, remp_q, remp_d;
   logic [3:0]                        sid_q, sid_d;

   assign raw = {SW2, KEY_SEL, KEY_DOWN, KEY_UP, KEY_RIGHT, KEY_LEFT};

   // ---------------------------------------------------------------- input conditioning
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q   <= IN_RST;
         sync2_q   <= IN_RST;
         db_q      <= IN_RST;
         db_prev_q <= IN_RST;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
      end
   end

   // The counter only runs while the synced level disagrees with the accepted
   // level; any agreement (i.e. a bounce back) restarts the stability window.
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NCH; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DB_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Presses are debounced 1->0 edges; releases are ignored.
   assign press_evt = db_prev_q[4:0] & ~db_q[4:0];
   assign mode      = db_q[K_MODE];
   assign mode_chg  = db_prev_q[K_MODE] ^ db_q[K_MODE];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (FrameStart && (|pend_q)) state_d = APPLY;
         APPLY:   state_d = svc[K_SEL] ? PULSE : IDLE;
         PULSE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (mode_chg) state_d = IDLE;
   end

   // Service decode: exactly one flag per APPLY, SEL > UP > DOWN > LEFT > RIGHT.
   always_comb begin
      svc = '0;
      if (state_q == APPLY && !mode_chg) begin
         if      (pend_q[K_SEL])   svc[K_SEL]   = 1'b1;
         else if (pend_q[K_UP])    svc[K_UP]    = 1'b1;
         else if (pend_q[K_DOWN])  svc[K_DOWN]  = 1'b1;
         else if (pend_q[K_LEFT])  svc[K_LEFT]  = 1'b1;
         else if (pend_q[K_RIGHT]) svc[K_RIGHT] = 1'b1;
      end
   end

   // ---------------------------------------------------------------- pending flags
   // A press landing in the FrameStart cycle is only visible in pend_q a cycle
   // later, so it waits for the next frame.
   always_comb begin
      pend_d = (pend_q & ~svc) | press_evt;
      if (mode_chg) pend_d = '0;
   end

   // ---------------------------------------------------------------- cursors
   assign row      = grid_q[3:2];
   assign col      = grid_q[1:0];
   assign bsk_last = BasketCount - 4'd1;

   always_comb begin
      row_n = row;
      col_n = col;
      if (svc[K_UP])    row_n = (row == 2'd0) ? 2'd2 : row - 2'd1;
      if (svc[K_DOWN])  row_n = (row == 2'd2) ? 2'd0 : row + 2'd1;
      if (svc[K_LEFT])  col_n = col - 2'd1;   // 2-bit wrap 0->3
      if (svc[K_RIGHT]) col_n = col + 2'd1;   // 2-bit wrap 3->0
      grid_d = mode ? grid_q : {row_n, col_n};
   end

   always_comb begin
      bsk_d = bsk_q;
      if (mode && svc[K_UP])   bsk_d = (bsk_q == 4'd0) ? bsk_last : bsk_q - 4'd1;
      if (mode && svc[K_DOWN]) bsk_d = (bsk_q >= bsk_last) ? 4'd0 : bsk_q + 4'd1;
      // Clamp tracks the basket shrinking and wins over any move this cycle.
      if (BasketCount == 4'd0)        bsk_d = 4'd0;
      else if (bsk_q >= BasketCount)  bsk_d = bsk_last;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend_q <= '0;
         grid_q <= '0;
         bsk_q  <= '0;
      end else begin
         pend_q <= pend_d;
         grid_q <= grid_d;
         bsk_q  <= bsk_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   // Registered from the next-state cursors so the highlight moves in the same
   // cycle the cursor register does, and the pulse register lines up with PULSE.
   always_comb begin
      selp_d = svc[K_SEL] && !mode;
      remp_d = svc[K_SEL] && mode && (BasketCount != 4'd0);
      sid_d  = sid_q;
      if (selp_d) sid_d = grid_q;
      if (remp_d) sid_d = bsk_d;
      if (!mode) begin
         hpl_d = 12'd1 << grid_d;
         cur_d = grid_d;
      end else if (BasketCount != 4'd0) begin
         hpl_d = 12'd1 << bsk_d;
         cur_d = bsk_d;
      end else begin
         hpl_d = '0;
         cur_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hpl_q  <= 12'h001;
         cur_q  <= '0;
         selp_q <= 1'b0;
         remp_q <= 1'b0;
         sid_q  <= '0;
      end else begin
         hpl_q  <= hpl_d;
         cur_q  <= cur_d;
         selp_q <= selp_d;
         remp_q <= remp_d;
         sid_q  <= sid_d;
      end
   end

   assign HighlightedProductList = hpl_q;
   assign CursorIndex            = cur_q;
   assign SelectPulse            = selp_q;
   assign RemovePulse            = remp_q;
   assign SelectedID             = sid_q;

endmodule
